// File: rtl/ap_ctrl_pkg.sv
// State encodings and shared constants for the fetch-side control path.
// The program counter compares against ST_SENT_INS, so these values are fixed.
package ap_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_START     = 4'd1,
        ST_LOAD_REQ  = 4'd2,
        ST_SENT_INS  = 4'd3,
        ST_LOAD_DATA = 4'd4
    } ins_cache_state_e;

    localparam int unsigned LOAD_TIMES_W   = 10;
    // One instruction occupies 8 bytes in DDR.
    localparam int unsigned INS_BYTES_LOG2 = 3;

endpackage

// File: rtl/instruction_cache_if.sv
// DDR block-read port between the instruction cache (master) and the memory controller (slave).
interface instruction_cache_if #(
    parameter int unsigned ADDR_WIDTH_MEM = 16,
    parameter int unsigned ISA_WIDTH      = 64,
    parameter int unsigned DDR_ADDR_WIDTH = 28
);
    logic                      ddr_rd_req;
    logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr;
    logic [ADDR_WIDTH_MEM-1:0] ddr_rd_len;
    logic                      ddr_rd_ack;
    logic [ISA_WIDTH-1:0]      ddr_rd_data;
    logic                      ddr_rd_data_valid;

    modport master (
        output ddr_rd_req, ddr_rd_addr, ddr_rd_len,
        input  ddr_rd_ack, ddr_rd_data, ddr_rd_data_valid
    );

    modport slave (
        input  ddr_rd_req, ddr_rd_addr, ddr_rd_len,
        output ddr_rd_ack, ddr_rd_data, ddr_rd_data_valid
    );
endinterface

// File: rtl/instruction_cache_ins_ram.sv
// Single-port instruction window store with registered read; the read register
// doubles as the cache's ins_out and holds its value when not read.
module ins_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instruction_cache.sv
// One-window instruction cache: refills an ISA_DEPTH-instruction window from DDR
// whenever addr_ins leaves it, and serves one instruction per cycle while hitting.
module instruction_cache
    import ap_ctrl_pkg::*;
#(
    parameter int unsigned               ADDR_WIDTH_MEM  = 16,
    parameter int unsigned               ISA_DEPTH       = 64,
    parameter int unsigned               TOTAL_ISA_DEPTH = 128,
    parameter int unsigned               ISA_WIDTH       = 64,
    parameter int unsigned               DDR_ADDR_WIDTH  = 28,
    parameter logic [DDR_ADDR_WIDTH-1:0] ISA_BASE_ADDR   = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
    output logic [ISA_WIDTH-1:0]      ins_out,
    output logic [ADDR_WIDTH_MEM-1:0] addr_ins_out,
    output logic                      ins_cache_rdy,
    output logic [3:0]                st_cur_ins_cache,
    output logic [LOAD_TIMES_W-1:0]   load_times,
    instruction_cache_if.master       ddr
);
    localparam int unsigned BEAT_W = $clog2(ISA_DEPTH);

    ins_cache_state_e          state_q, state_d;
    logic [LOAD_TIMES_W-1:0]   load_times_q, load_times_d;
    logic [LOAD_TIMES_W-1:0]   target_q, target_d;
    logic [BEAT_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic                      req_q, req_d;
    logic [DDR_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                      rdy_q, rdy_d;
    logic [ADDR_WIDTH_MEM-1:0] addr_ins_out_q, addr_ins_out_d;

    logic [ADDR_WIDTH_MEM-1:0] win_idx;
    logic                      in_range, hit;
    logic                      ram_we, ram_re;
    logic [BEAT_W-1:0]         ram_addr;

    function automatic logic [DDR_ADDR_WIDTH-1:0] blk_addr(input logic [LOAD_TIMES_W-1:0] win);
        return ISA_BASE_ADDR + (DDR_ADDR_WIDTH'(win) << (BEAT_W + INS_BYTES_LOG2));
    endfunction

    assign win_idx  = addr_ins >> BEAT_W;
    assign in_range = 32'(addr_ins) < TOTAL_ISA_DEPTH;
    // load_times is window+1, so the loaded window is load_times-1.
    assign hit      = in_range && (win_idx == ADDR_WIDTH_MEM'(load_times_q) - ADDR_WIDTH_MEM'(1));

    always_comb begin
        state_d        = state_q;
        load_times_d   = load_times_q;
        target_d       = target_q;
        beat_cnt_d     = beat_cnt_q;
        req_d          = 1'b0;
        rd_addr_d      = rd_addr_q;
        rdy_d          = rdy_q;
        addr_ins_out_d = addr_ins_out_q;
        ram_we         = 1'b0;
        ram_re         = 1'b0;
        ram_addr       = addr_ins[BEAT_W-1:0];

        unique case (state_q)
            ST_START: begin
                target_d  = '0;
                req_d     = 1'b1;
                rd_addr_d = blk_addr('0);
                state_d   = ST_LOAD_REQ;
            end
            ST_LOAD_REQ: begin
                req_d = ~ddr.ddr_rd_ack;
                if (ddr.ddr_rd_ack) begin
                    state_d = ST_LOAD_DATA;
                end
            end
            ST_LOAD_DATA: begin
                if (ddr.ddr_rd_data_valid) begin
                    ram_we     = 1'b1;
                    ram_addr   = beat_cnt_q;
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (beat_cnt_q == BEAT_W'(ISA_DEPTH - 1)) begin
                        beat_cnt_d   = '0;
                        load_times_d = target_q + LOAD_TIMES_W'(1);
                        state_d      = ST_SENT_INS;
                    end
                end
            end
            ST_SENT_INS: begin
                if (hit) begin
                    ram_re         = 1'b1;
                    addr_ins_out_d = addr_ins;
                    rdy_d          = 1'b1;
                end else if (in_range) begin
                    rdy_d     = 1'b0;
                    target_d  = LOAD_TIMES_W'(win_idx);
                    req_d     = 1'b1;
                    rd_addr_d = blk_addr(LOAD_TIMES_W'(win_idx));
                    state_d   = ST_LOAD_REQ;
                end else begin
                    // Jump-pending and other out-of-range indices park here without loading.
                    rdy_d = 1'b0;
                end
            end
            default: state_d = ST_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_START;
            load_times_q   <= '0;
            target_q       <= '0;
            beat_cnt_q     <= '0;
            req_q          <= 1'b0;
            rd_addr_q      <= '0;
            rdy_q          <= 1'b0;
            addr_ins_out_q <= '0;
        end else begin
            state_q        <= state_d;
            load_times_q   <= load_times_d;
            target_q       <= target_d;
            beat_cnt_q     <= beat_cnt_d;
            req_q          <= req_d;
            rd_addr_q      <= rd_addr_d;
            rdy_q          <= rdy_d;
            addr_ins_out_q <= addr_ins_out_d;
        end
    end

    ins_ram #(
        .DEPTH (ISA_DEPTH),
        .WIDTH (ISA_WIDTH)
    ) u_ins_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ddr.ddr_rd_data),
        .rdata (ins_out)
    );

    assign addr_ins_out     = addr_ins_out_q;
    assign ins_cache_rdy    = rdy_q;
    assign st_cur_ins_cache = state_q;
    assign load_times       = load_times_q;
    assign ddr.ddr_rd_req   = req_q;
    assign ddr.ddr_rd_addr  = rd_addr_q;
    assign ddr.ddr_rd_len   = ADDR_WIDTH_MEM'(ISA_DEPTH);

endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: random program image served by a DDR responder model,
// with expected fetch results derived from the window/range rules.
module tb_instruction_cache;
    localparam int AW    = 16;
    localparam int DEPTH = 64;
    localparam int TOTAL = 128;
    localparam int W     = 64;
    localparam int DAW   = 28;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  addr_ins;
    logic [W-1:0]   ins_out;
    logic [AW-1:0]  addr_ins_out;
    logic           rdy;
    logic [3:0]     st;
    logic [9:0]     load_times;

    instruction_cache_if #(.ADDR_WIDTH_MEM(AW), .ISA_WIDTH(W), .DDR_ADDR_WIDTH(DAW)) ddr_bus ();

    instruction_cache #(
        .ADDR_WIDTH_MEM  (AW),
        .ISA_DEPTH       (DEPTH),
        .TOTAL_ISA_DEPTH (TOTAL),
        .ISA_WIDTH       (W),
        .DDR_ADDR_WIDTH  (DAW),
        .ISA_BASE_ADDR   ('0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .addr_ins         (addr_ins),
        .ins_out          (ins_out),
        .addr_ins_out     (addr_ins_out),
        .ins_cache_rdy    (rdy),
        .st_cur_ins_cache (st),
        .load_times       (load_times),
        .ddr              (ddr_bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] prog [TOTAL];
    int checks, failures;
    int ack_delay, gap_mode;
    int r_wait, r_beat, r_base;
    bit r_busy, r_gap;
    int w_req_cycles, w_unstable, w_lt_early;
    logic [DAW-1:0] w_addr;
    logic [3:0] w_first_state;

    // DDR model: acks after ack_delay cycles of req, then streams the block (optionally gapped).
    initial begin : ddr_responder
        ddr_bus.ddr_rd_ack        = 1'b0;
        ddr_bus.ddr_rd_data_valid = 1'b0;
        ddr_bus.ddr_rd_data       = '0;
        r_busy = 1'b0; r_gap = 1'b0; r_wait = 0; r_beat = 0; r_base = 0;
        forever begin
            @(posedge clk); #1;
            ddr_bus.ddr_rd_ack        = 1'b0;
            ddr_bus.ddr_rd_data_valid = 1'b0;
            if (rst) begin
                r_busy = 1'b0;
                r_wait = 0;
            end else if (!r_busy) begin
                if (ddr_bus.ddr_rd_req) begin
                    if (r_wait >= ack_delay) begin
                        ddr_bus.ddr_rd_ack = 1'b1;
                        r_busy = 1'b1; r_wait = 0; r_beat = 0;
                        r_gap  = (gap_mode != 0);
                        r_base = int'(ddr_bus.ddr_rd_addr >> 3);
                    end else begin
                        r_wait++;
                    end
                end
            end else if (r_gap) begin
                r_gap = 1'b0;
            end else begin
                ddr_bus.ddr_rd_data_valid = 1'b1;
                ddr_bus.ddr_rd_data       = prog[(r_base + r_beat) % TOTAL];
                r_beat++;
                r_gap = (gap_mode != 0);
                if (r_beat == DEPTH) r_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for ins_cache_rdy, monitoring the request and load_times meanwhile.
    task automatic wait_rdy(input int budget, output int cyc);
        logic [9:0] lt0;
        lt0 = load_times;
        cyc = 0; w_req_cycles = 0; w_unstable = 0; w_lt_early = 0;
        w_addr = '1; w_first_state = '0;
        do begin
            @(negedge clk);
            if (cyc == 0) w_first_state = st;
            if (ddr_bus.ddr_rd_req) begin
                if (w_req_cycles > 0 && ddr_bus.ddr_rd_addr !== w_addr) w_unstable++;
                w_addr = ddr_bus.ddr_rd_addr;
                w_req_cycles++;
            end
            if (st != 4'd3 && load_times != lt0) w_lt_early++;
            if (rdy !== 1'b1) cyc++;
        end while (rdy !== 1'b1 && cyc < budget);
        check("wait_rdy_timeout", 64'(rdy), 64'd1);
    endtask

    task automatic check_hit(input string tag, input int a);
        check({tag, "_ins"}, ins_out, prog[a]);
        check({tag, "_addr"}, 64'(addr_ins_out), 64'(a));
        check({tag, "_rdy"}, 64'(rdy), 64'd1);
    endtask

    initial begin : stimulus
        int cyc, a, w, kind, viol, n, m_lt;
        checks = 0; failures = 0; ack_delay = 0; gap_mode = 0;
        for (int i = 0; i < TOTAL; i++) prog[i] = {$urandom(), $urandom()};

        // Reset values
        rst = 1'b1; addr_ins = '0;
        @(negedge clk);
        check("rst_state", 64'(st), 64'd1);
        check("rst_rdy", 64'(rdy), 64'd0);
        check("rst_ins_out", ins_out, 64'd0);
        check("rst_addr_out", 64'(addr_ins_out), 64'd0);
        check("rst_load_times", 64'(load_times), 64'd0);
        check("rst_req", 64'(ddr_bus.ddr_rd_req), 64'd0);
        check("rst_rd_addr", 64'(ddr_bus.ddr_rd_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // First load of window 0
        wait_rdy(400, cyc);
        check("first_rd_addr", 64'(w_addr), 64'h0);
        check("first_rd_len", 64'(ddr_bus.ddr_rd_len), 64'd64);
        check("first_penalty", 64'(cyc), 64'd66);
        check("first_load_times", 64'(load_times), 64'd1);
        check("first_state", 64'(st), 64'd3);
        check_hit("first_hit", 0);

        // Sequential hits, one per cycle
        for (int i = 0; i < DEPTH; i++) begin
            addr_ins = AW'(i);
            @(negedge clk);
            check_hit("seq", i);
        end

        // Window boundary
        addr_ins = AW'(64);
        wait_rdy(400, cyc);
        check("bound_first_state", 64'(w_first_state), 64'd2);
        check("bound_penalty", 64'(cyc), 64'd66);
        check("bound_rd_addr", 64'(w_addr), 64'h200);
        check("bound_load_times", 64'(load_times), 64'd2);
        check_hit("bound_hit", 64);

        // Jump-pending hold
        addr_ins = 16'h8000;
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (ddr_bus.ddr_rd_req !== 1'b0 || rdy !== 1'b0 || st !== 4'd3 || load_times !== 10'd2)
                viol++;
        end
        check("jump_hold_viol", 64'(viol), 64'd0);
        addr_ins = AW'(5);
        wait_rdy(400, cyc);
        check("jump_first_state", 64'(w_first_state), 64'd2);
        check("jump_rd_addr", 64'(w_addr), 64'h0);
        check("jump_load_times", 64'(load_times), 64'd1);
        check_hit("jump_hit", 5);

        // Reset during load of window 1
        addr_ins = AW'(70);
        n = 0;
        while (!(r_busy && r_beat >= 20) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("midload_reached", 64'(n < 300), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midload_req", 64'(ddr_bus.ddr_rd_req), 64'd0);
        check("midload_load_times", 64'(load_times), 64'd0);
        check("midload_state", 64'(st), 64'd1);
        check("midload_rdy", 64'(rdy), 64'd0);
        rst = 1'b0;
        addr_ins = AW'(3);
        wait_rdy(400, cyc);
        check("reload_rd_addr", 64'(w_addr), 64'h0);
        check("reload_load_times", 64'(load_times), 64'd1);
        check_hit("reload_hit", 3);

        // Stalled DDR: late ack, gapped beats
        ack_delay = 7; gap_mode = 1;
        a = 64 + int'($urandom_range(0, 63));
        addr_ins = AW'(a);
        wait_rdy(800, cyc);
        check("stall_req_cycles", 64'(w_req_cycles), 64'd8);
        check("stall_req_unstable", 64'(w_unstable), 64'd0);
        check("stall_lt_early", 64'(w_lt_early), 64'd0);
        check("stall_rd_addr", 64'(w_addr), 64'h200);
        check("stall_load_times", 64'(load_times), 64'd2);
        check_hit("stall_hit", a);
        for (int i = 0; i < DEPTH; i++) begin
            addr_ins = AW'(64 + i);
            @(negedge clk);
            check_hit("stall_seq", 64 + i);
        end

        // Randomized mix against the window model
        m_lt = 2;
        for (int it = 0; it < 30; it++) begin
            kind = int'($urandom_range(0, 3));
            if (kind <= 1) begin
                a = (m_lt - 1) * DEPTH + int'($urandom_range(0, DEPTH - 1));
                addr_ins = AW'(a);
                @(negedge clk);
                check_hit("rnd_hit", a);
            end else if (kind == 2) begin
                a = int'($urandom_range(TOTAL, 65535));
                addr_ins = AW'(a);
                @(negedge clk);
                check("rnd_oor_rdy", 64'(rdy), 64'd0);
                check("rnd_oor_req", 64'(ddr_bus.ddr_rd_req), 64'd0);
                check("rnd_oor_lt", 64'(load_times), 64'(m_lt));
            end else begin
                w = int'($urandom_range(0, TOTAL / DEPTH - 1));
                a = w * DEPTH + int'($urandom_range(0, DEPTH - 1));
                ack_delay = int'($urandom_range(0, 3));
                gap_mode = int'($urandom_range(0, 1));
                addr_ins = AW'(a);
                if (w == m_lt - 1) begin
                    @(negedge clk);
                    check_hit("rnd_same_win", a);
                end else begin
                    wait_rdy(800, cyc);
                    m_lt = w + 1;
                    check("rnd_miss_rd_addr", 64'(w_addr), 64'(w * DEPTH * 8));
                    check("rnd_miss_lt", 64'(load_times), 64'(m_lt));
                    check_hit("rnd_miss_hit", a);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
